// File: rtl/mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul8_seq_ctrl
// Purpose  : Sequential 8x8 unsigned multiplier controller. Walks the four
//            nibble pairs of an operand pair through an external 4x4
//            combinational array multiplier, one pair per cycle, and sums
//            the shifted 8-bit partial products into a 16-bit result.
//            Operands and result each use a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mul8_seq_ctrl #(
  parameter int ZERO_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [3:0]  nib_a,
  output logic [3:0]  nib_b,
  input  logic [7:0]  pp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  localparam bit BYPASS_EN = (ZERO_BYPASS != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  step;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [15:0] acc;

  logic        accept;
  logic        zero_op;
  logic [15:0] pp_term;

  // Handshake qualifiers; a zero operand is detected on the raw inputs so the
  // bypass decision is taken on the accepting edge itself.
  assign accept  = in_valid && (state == IDLE);
  assign zero_op = (a == 8'd0) || (b == 8'd0);

  // Status outputs decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // The accumulator is the product register: it is stable throughout DONE
  // and keeps its value after the result handshake until the next accept.
  assign product = acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus nibble selection and partial-product alignment.
  always_comb begin
    state_nxt = state;
    nib_a     = 4'd0;
    nib_b     = 4'd0;
    pp_term   = 16'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (BYPASS_EN && zero_op) begin
            state_nxt = DONE;
          end else begin
            state_nxt = MUL;
          end
        end
      end
      MUL: begin
        case (step)
          2'd0: begin
            nib_a   = a_r[3:0];
            nib_b   = b_r[3:0];
            pp_term = {8'd0, pp};
          end
          2'd1: begin
            nib_a   = a_r[7:4];
            nib_b   = b_r[3:0];
            pp_term = {4'd0, pp, 4'd0};
          end
          2'd2: begin
            nib_a   = a_r[3:0];
            nib_b   = b_r[7:4];
            pp_term = {4'd0, pp, 4'd0};
          end
          default: begin
            nib_a   = a_r[7:4];
            nib_b   = b_r[7:4];
            pp_term = {pp, 8'd0};
          end
        endcase
        if (step == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, step counter and accumulation. The largest possible
  // sum is 0xFE01, so the 16-bit accumulator never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= 8'd0;
      b_r  <= 8'd0;
      acc  <= 16'd0;
      step <= 2'd0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b;
      acc  <= 16'd0;
      step <= 2'd0;
    end else if (state == MUL) begin
      acc  <= acc + pp_term;
      step <= step + 2'd1;
    end
  end

endmodule
`default_nettype wire
